fsm_trace_recorder: RTL and testbench

//  Watches NB_CH FSM state buses and records each state change as a timestamped
//  {ts, ch, prev, next} entry in a DEPTH-entry FIFO. Entries are drained over
//  a valid/ready interface for the SVUT bench or a debug port.

---
 rtl/fsm_trace_recorder.sv | 146 ++++++++++++++
 tb/tb_fsm_trace_recorder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_trace_recorder.sv
// Records state changes of NB_CH observed FSM buses as {ts, ch, prev, next}
// entries in a first-word-fall-through FIFO drained over valid/ready.
module fsm_trace_recorder #(
   parameter           NAME    = "fsm_trace",
   parameter int       NB_CH   = 2,
   parameter int       STATE_W = 4,
   parameter int       DEPTH   = 16,
   parameter int       TS_W    = 16,
   localparam int      CH_W    = (NB_CH > 1) ? $clog2(NB_CH) : 1,
   localparam int      REC_W   = TS_W + CH_W + 2*STATE_W,
   localparam int      CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [NB_CH*STATE_W-1:0] state_in,
   output logic                     trc_valid,
   input  logic                     trc_ready,
   output logic [REC_W-1:0]         trc_data,
   output logic [CNT_W-1:0]         trc_count,
   output logic                     overflow,
   output logic [15:0]              drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = TS_W + 2*STATE_W;

   if (NB_CH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || $bits(NAME) == 0) begin : g_param_check
      $error("fsm_trace_recorder: illegal parameter set");
   end

   logic [TS_W-1:0]          ts_q;
   logic                     armed_q;
   logic [NB_CH*STATE_W-1:0] prev_q;
   logic [NB_CH-1:0]         pend_vld_q, pend_vld_d;
   logic [PW-1:0]            pend_q [NB_CH];
   logic [PW-1:0]            pend_d [NB_CH];
   logic [REC_W-1:0]         mem_q  [DEPTH];
   logic [AW:0]              wr_ptr_q, rd_ptr_q;
   logic                     overflow_q, overflow_d;
   logic [15:0]              drop_cnt_q, drop_cnt_d;

   logic                     empty, full, pop, push, win_vld, grant_c;
   logic [CH_W-1:0]          win_ch;
   logic [PW-1:0]            win_pend;
   logic [REC_W-1:0]         push_rec;
   logic [NB_CH-1:0]         evt;
   logic [15:0]              drop_inc;
   logic [16:0]              drop_sum;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = !empty && trc_ready;

   // Fixed priority: the lowest-index pending channel wins the single write slot.
   always_comb begin
      win_vld = 1'b0;
      win_ch  = '0;
      for (int c = NB_CH - 1; c >= 0; c--) begin
         if (pend_vld_q[c]) begin
            win_vld = 1'b1;
            win_ch  = CH_W'(c);
         end
      end
   end

   assign push     = win_vld && (!full || pop);
   assign win_pend = pend_q[win_ch];
   assign push_rec = {win_pend[PW-1 -: TS_W], win_ch, win_pend[2*STATE_W-1:0]};

   always_comb begin
      for (int c = 0; c < NB_CH; c++) begin
         evt[c] = armed_q && enable &&
                  (state_in[c*STATE_W +: STATE_W] != prev_q[c*STATE_W +: STATE_W]);
      end
   end

   // A slot granted this edge is free again for a same-edge event.
   always_comb begin
      drop_inc   = '0;
      grant_c    = 1'b0;
      pend_vld_d = pend_vld_q;
      for (int c = 0; c < NB_CH; c++) begin
         pend_d[c] = pend_q[c];
         grant_c   = push && (win_ch == CH_W'(c));
         if (grant_c) pend_vld_d[c] = 1'b0;
         if (evt[c]) begin
            if (!pend_vld_d[c]) begin
               pend_vld_d[c] = 1'b1;
               pend_d[c]     = {ts_q, prev_q[c*STATE_W +: STATE_W], state_in[c*STATE_W +: STATE_W]};
            end else begin
               drop_inc = drop_inc + 16'd1;
            end
         end
      end
      overflow_d = overflow_q || (drop_inc != 16'd0);
      drop_sum   = {1'b0, drop_cnt_q} + {1'b0, drop_inc};
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ts_q       <= '0;
         armed_q    <= 1'b0;
         prev_q     <= '0;
         pend_vld_q <= '0;
         for (int c = 0; c < NB_CH; c++) pend_q[c] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (enable) begin
            ts_q    <= ts_q + 1'b1;
            armed_q <= 1'b1;
         end
         prev_q <= state_in;
         if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pend_vld_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            pend_vld_q <= pend_vld_d;
            for (int c = 0; c < NB_CH; c++) pend_q[c] <= pend_d[c];
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
   end

   assign trc_valid = !empty;
   assign trc_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign trc_count = wr_ptr_q - rd_ptr_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fsm_trace_recorder.sv
// Directed plus randomized bench for fsm_trace_recorder against a queue-based
// reference model; TS_W is 4 so timestamp wrap is reachable quickly.
module tb_fsm_trace_recorder;

   localparam int NB_CH   = 2;
   localparam int STATE_W = 4;
   localparam int DEPTH   = 16;
   localparam int TS_W    = 4;
   localparam int CH_W    = 1;
   localparam int REC_W   = TS_W + CH_W + 2*STATE_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic                     aclk = 1'b0;
   logic                     areset;
   logic                     enable;
   logic                     clear;
   logic [NB_CH*STATE_W-1:0] state_in;
   logic                     trc_valid;
   logic                     trc_ready;
   logic [REC_W-1:0]         trc_data;
   logic [CNT_W-1:0]         trc_count;
   logic                     overflow;
   logic [15:0]              drop_cnt;

   always #5 aclk = ~aclk;

   fsm_trace_recorder #(
      .NAME("fsm_trace"), .NB_CH(NB_CH), .STATE_W(STATE_W), .DEPTH(DEPTH), .TS_W(TS_W)
   ) dut (
      .aclk(aclk), .areset(areset), .enable(enable), .clear(clear),
      .state_in(state_in), .trc_valid(trc_valid), .trc_ready(trc_ready),
      .trc_data(trc_data), .trc_count(trc_count), .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   // Reference model: trace FIFO as a queue, one pending record per channel.
   int               m_ts;
   bit               m_armed;
   logic [STATE_W-1:0] m_prev [NB_CH];
   bit               m_pv   [NB_CH];
   logic [REC_W-1:0] m_prec [NB_CH];
   logic [REC_W-1:0] exp_q[$];
   bit               m_ovf;
   int               m_drops;

   int vectors;
   int miscompares;

   function automatic logic [REC_W-1:0] mk_rec(input int ts, input int ch, input int p, input int n);
      logic [TS_W-1:0]    t;
      logic [CH_W-1:0]    c;
      logic [STATE_W-1:0] pp, nn;
      t  = ts[TS_W-1:0];
      c  = ch[CH_W-1:0];
      pp = p[STATE_W-1:0];
      nn = n[STATE_W-1:0];
      return {t, c, pp, nn};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ts    = 0;
      m_armed = 0;
      for (int c = 0; c < NB_CH; c++) begin
         m_prev[c] = '0;
         m_pv[c]   = 0;
         m_prec[c] = '0;
      end
      exp_q.delete();
      m_ovf   = 0;
      m_drops = 0;
   endtask

   task automatic model_edge();
      bit pop;
      int win;
      logic [STATE_W-1:0] s;
      pop = (exp_q.size() > 0) && trc_ready;
      if (clear) begin
         exp_q.delete();
         for (int c = 0; c < NB_CH; c++) m_pv[c] = 0;
         m_ovf   = 0;
         m_drops = 0;
      end else begin
         win = -1;
         for (int c = NB_CH - 1; c >= 0; c--) if (m_pv[c]) win = c;
         if (pop) void'(exp_q.pop_front());
         if (win >= 0 && exp_q.size() < DEPTH) begin
            exp_q.push_back(m_prec[win]);
            m_pv[win] = 0;
         end
         if (m_armed && enable) begin
            for (int c = 0; c < NB_CH; c++) begin
               s = state_in[c*STATE_W +: STATE_W];
               if (s != m_prev[c]) begin
                  if (!m_pv[c]) begin
                     m_pv[c]   = 1;
                     m_prec[c] = mk_rec(m_ts, c, int'(m_prev[c]), int'(s));
                  end else begin
                     m_ovf   = 1;
                     m_drops = m_drops + 1;
                  end
               end
            end
         end
      end
      for (int c = 0; c < NB_CH; c++) m_prev[c] = state_in[c*STATE_W +: STATE_W];
      if (enable) begin
         m_armed = 1;
         m_ts    = (m_ts + 1) % (1 << TS_W);
      end
   endtask

   task automatic check_outputs();
      logic [REC_W-1:0] ed;
      ed = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("trc_valid", trc_valid, exp_q.size() != 0);
      chk("trc_data",  trc_data,  ed);
      chk("trc_count", trc_count, exp_q.size());
      chk("overflow",  overflow,  m_ovf);
      chk("drop_cnt",  drop_cnt,  (m_drops > 65535) ? 65535 : m_drops);
   endtask

   task automatic tick();
      model_edge();
      @(posedge aclk);
      #1;
      check_outputs();
   endtask

   task automatic set_ch(input int c, input int v);
      state_in[c*STATE_W +: STATE_W] = v[STATE_W-1:0];
   endtask

   task automatic wait_ts(input int t);
      for (int i = 0; i < 20 && m_ts != t; i++) tick();
   endtask

   task automatic spread_changes(input int n);
      for (int i = 0; i < n; i++) begin
         set_ch(0, (i % 2 == 0) ? 8 : 7);
         tick();
         tick();
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      areset      = 1'b1;
      enable      = 1'b0;
      clear       = 1'b0;
      trc_ready   = 1'b0;
      state_in    = {4'd2, 4'd1};
      model_reset();
      #12;
      check_outputs();
      areset = 1'b0;

      // Reset exit: the first enabled edge only primes.
      enable = 1'b1;
      tick();
      chk("t1_count", trc_count, 0);
      chk("t1_valid", trc_valid, 0);

      // Single change ch0 1->3 at ts=5, visible one edge later and held while stalled.
      wait_ts(5);
      set_ch(0, 3);
      tick();
      chk("t2_valid_early", trc_valid, 0);
      tick();
      chk("t2_valid", trc_valid, 1);
      chk("t2_data", trc_data, {4'd5, 1'b0, 4'd1, 4'd3});
      tick();
      chk("t2_data_stable", trc_data, {4'd5, 1'b0, 4'd1, 4'd3});
      trc_ready = 1'b1;
      tick();
      chk("t2_drained", trc_count, 0);

      // Both channels change on the same edge at ts=9.
      wait_ts(9);
      set_ch(0, 5);
      set_ch(1, 6);
      tick();
      tick();
      chk("t3_first", trc_data, mk_rec(9, 0, 3, 5));
      tick();
      chk("t3_second", trc_data, mk_rec(9, 1, 2, 6));
      chk("t3_count", trc_count, 1);
      tick();
      chk("t3_empty", trc_count, 0);

      // Fill FIFO with a stalled consumer, then one pending, then a drop.
      trc_ready = 1'b0;
      spread_changes(DEPTH + 1);
      chk("t4_full", trc_count, DEPTH);
      chk("t4_no_ovf", overflow, 0);
      chk("t4_no_drop", drop_cnt, 0);
      set_ch(0, 9);
      tick();
      chk("t4_ovf", overflow, 1);
      chk("t4_drop", drop_cnt, 1);

      // Push and pop on the same edge at full, then drain in order.
      trc_ready = 1'b1;
      tick();
      chk("t5_full_hold", trc_count, DEPTH);
      for (int i = 0; i < DEPTH + 4; i++) tick();
      chk("t5_drained", trc_count, 0);

      // Clear while full with overflow set.
      trc_ready = 1'b0;
      spread_changes(DEPTH + 1);
      set_ch(0, 10);
      tick();
      chk("t6_pre_ovf", overflow, 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t6_count", trc_count, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_drop", drop_cnt, 0);
      set_ch(0, 11);
      tick();
      tick();
      chk("t6_next", trc_count, 1);
      trc_ready = 1'b1;
      tick();

      // Timestamp wrap 15 -> 0.
      trc_ready = 1'b0;
      wait_ts(15);
      set_ch(0, 12);
      tick();
      set_ch(0, 13);
      tick();
      tick();
      chk("t7_ts_a", trc_data[REC_W-1 -: TS_W], 15);
      trc_ready = 1'b1;
      tick();
      chk("t7_ts_b", trc_data[REC_W-1 -: TS_W], 0);
      tick();

      // Randomized traffic: slow consumer first, then fast, with clears and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            #2 areset = 1'b1;
            #1;
            model_reset();
            check_outputs();
            #1 areset = 1'b0;
         end
         enable    = ($urandom_range(0, 9) != 0);
         trc_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clear     = ($urandom_range(0, 149) == 0);
         for (int c = 0; c < NB_CH; c++)
            if ($urandom_range(0, 2) == 0) set_ch(c, $urandom_range(0, 15));
         tick();
      end
      clear = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
